// File: rtl/cv32e40x_pkg.sv
// Shared type definitions for the cv32e40x MPU response path.
package cv32e40x_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        ERR_WAIT = 1'b1
    } mpu_resp_state_e;

endpackage : cv32e40x_pkg

// File: rtl/cv32e40x_resp_cnt.sv
// Outstanding bus transaction counter with a full flag.
module cv32e40x_resp_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign full = (cnt == CNT_W'(MAX_OUTSTANDING));

endmodule : cv32e40x_resp_cnt

// File: rtl/cv32e40x_mpu_resp.sv
// MPU response sequencer: blocks PMA-faulting requests and returns their error in bus order.
// Optional sticky spurious-response flag: CV32E40X_MPU_RESP_PROTOCOL_CHECK_EN.
module cv32e40x_mpu_resp
    import cv32e40x_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_trans_valid_i,
    output logic        core_trans_ready_o,
    input  logic [31:0] core_trans_addr_i,
    input  logic        core_trans_we_i,

    input  logic        pma_err_i,
    input  logic        pma_bufferable_i,
    input  logic        pma_cacheable_i,

    output logic        bus_trans_valid_o,
    input  logic        bus_trans_ready_i,
    output logic [31:0] bus_trans_addr_o,
    output logic        bus_trans_we_o,
    output logic        bus_trans_bufferable_o,
    output logic        bus_trans_cacheable_o,

    input  logic        bus_resp_valid_i,
    input  logic [31:0] bus_resp_rdata_i,
    input  logic        bus_resp_err_i,

    output logic        core_resp_valid_o,
    output logic [31:0] core_resp_rdata_o,
    output logic        core_resp_err_o,
    output logic        core_resp_pma_err_o,

    output logic        resp_protocol_err_o
);

    mpu_resp_state_e  state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_full;
    logic             cnt_zero;
    logic             bus_valid;
    logic             core_ready;
    logic             err_resp;
    logic             cnt_inc;
    logic             cnt_dec;

    cv32e40x_resp_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_resp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .cnt   (cnt),
        .full  (cnt_full)
    );

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request gating depends only on registered state, keeping bus_resp_* off the valid path.
    always_comb begin
        state_next = state;
        bus_valid  = 1'b0;
        core_ready = 1'b0;
        err_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (!cnt_full) begin
                    if (core_trans_valid_i && pma_err_i) begin
                        core_ready = 1'b1;
                        state_next = ERR_WAIT;
                    end else begin
                        bus_valid  = core_trans_valid_i;
                        core_ready = bus_trans_ready_i;
                    end
                end
            end
            ERR_WAIT: begin
                if (cnt_zero) begin
                    err_resp   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus_trans_valid_o      = bus_valid & rst_n;
    assign core_trans_ready_o     = core_ready & rst_n;
    assign bus_trans_addr_o       = core_trans_addr_i;
    assign bus_trans_we_o         = core_trans_we_i;
    assign bus_trans_bufferable_o = pma_bufferable_i;
    assign bus_trans_cacheable_o  = pma_cacheable_i;

    assign cnt_inc = bus_trans_valid_o & bus_trans_ready_i;
    assign cnt_dec = bus_resp_valid_i & ~cnt_zero;

    assign core_resp_valid_o   = rst_n & (err_resp | cnt_dec);
    assign core_resp_rdata_o   = err_resp ? '0 : bus_resp_rdata_i;
    assign core_resp_err_o     = ~err_resp & bus_resp_err_i;
    assign core_resp_pma_err_o = rst_n & err_resp;

`ifdef CV32E40X_MPU_RESP_PROTOCOL_CHECK_EN
    logic protocol_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            protocol_err_q <= 1'b0;
        end else if (bus_resp_valid_i && cnt_zero) begin
            protocol_err_q <= 1'b1;
        end
    end

    assign resp_protocol_err_o = protocol_err_q;
`else
    assign resp_protocol_err_o = 1'b0;
`endif

endmodule : cv32e40x_mpu_resp

// File: tb/tb_cv32e40x_mpu_resp.sv
// Directed self-checking bench for cv32e40x_mpu_resp (MAX_OUTSTANDING=2).
module tb_cv32e40x_mpu_resp;
    import cv32e40x_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        core_trans_valid_i;
    logic        core_trans_ready_o;
    logic [31:0] core_trans_addr_i;
    logic        core_trans_we_i;
    logic        pma_err_i;
    logic        pma_bufferable_i;
    logic        pma_cacheable_i;
    logic        bus_trans_valid_o;
    logic        bus_trans_ready_i;
    logic [31:0] bus_trans_addr_o;
    logic        bus_trans_we_o;
    logic        bus_trans_bufferable_o;
    logic        bus_trans_cacheable_o;
    logic        bus_resp_valid_i;
    logic [31:0] bus_resp_rdata_i;
    logic        bus_resp_err_i;
    logic        core_resp_valid_o;
    logic [31:0] core_resp_rdata_o;
    logic        core_resp_err_o;
    logic        core_resp_pma_err_o;
    logic        resp_protocol_err_o;

    int unsigned tests;
    int unsigned fails;
    logic        proto_exp;

    cv32e40x_mpu_resp #(
        .MAX_OUTSTANDING (2),
        .CNT_W           (3)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .core_trans_valid_i     (core_trans_valid_i),
        .core_trans_ready_o     (core_trans_ready_o),
        .core_trans_addr_i      (core_trans_addr_i),
        .core_trans_we_i        (core_trans_we_i),
        .pma_err_i              (pma_err_i),
        .pma_bufferable_i       (pma_bufferable_i),
        .pma_cacheable_i        (pma_cacheable_i),
        .bus_trans_valid_o      (bus_trans_valid_o),
        .bus_trans_ready_i      (bus_trans_ready_i),
        .bus_trans_addr_o       (bus_trans_addr_o),
        .bus_trans_we_o         (bus_trans_we_o),
        .bus_trans_bufferable_o (bus_trans_bufferable_o),
        .bus_trans_cacheable_o  (bus_trans_cacheable_o),
        .bus_resp_valid_i       (bus_resp_valid_i),
        .bus_resp_rdata_i       (bus_resp_rdata_i),
        .bus_resp_err_i         (bus_resp_err_i),
        .core_resp_valid_o      (core_resp_valid_o),
        .core_resp_rdata_o      (core_resp_rdata_o),
        .core_resp_err_o        (core_resp_err_o),
        .core_resp_pma_err_o    (core_resp_pma_err_o),
        .resp_protocol_err_o    (resp_protocol_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_trans_valid_i = 1'b0;
        core_trans_addr_i  = '0;
        core_trans_we_i    = 1'b0;
        pma_err_i          = 1'b0;
        pma_bufferable_i   = 1'b0;
        pma_cacheable_i    = 1'b0;
        bus_trans_ready_i  = 1'b1;
        bus_resp_valid_i   = 1'b0;
        bus_resp_rdata_i   = '0;
        bus_resp_err_i     = 1'b0;
    endtask

    // One accepted read handshake at the given address.
    task automatic issue(input logic [31:0] addr);
        core_trans_valid_i = 1'b1;
        core_trans_addr_i  = addr;
        pma_err_i          = 1'b0;
        cyc();
        core_trans_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n              = 1'b0;
        core_trans_valid_i = 1'b1;
        bus_resp_valid_i   = 1'b1;
        cyc();
        cyc();
        #1;
        tests++; if (bus_trans_valid_o !== 1'b0) begin fails++; $display("FAIL rst_bus_valid got %b want 0", bus_trans_valid_o); end
        tests++; if (core_trans_ready_o !== 1'b0) begin fails++; $display("FAIL rst_core_ready got %b want 0", core_trans_ready_o); end
        tests++; if (core_resp_valid_o !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b want 0", core_resp_valid_o); end
        tests++; if (dut.cnt !== 3'd0) begin fails++; $display("FAIL rst_cnt got %0d want 0", dut.cnt); end
        tests++; if (resp_protocol_err_o !== 1'b0) begin fails++; $display("FAIL rst_proto got %b want 0", resp_protocol_err_o); end
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        cyc();
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL rst_state got %0d want IDLE", dut.state); end
    endtask

    task automatic test_pass_through();
        core_trans_valid_i = 1'b1;
        core_trans_addr_i  = 32'h0000_0100;
        core_trans_we_i    = 1'b0;
        pma_bufferable_i   = 1'b1;
        pma_cacheable_i    = 1'b0;
        #1;
        tests++; if (bus_trans_valid_o !== 1'b1) begin fails++; $display("FAIL pt_bus_valid got %b want 1", bus_trans_valid_o); end
        tests++; if (core_trans_ready_o !== 1'b1) begin fails++; $display("FAIL pt_core_ready got %b want 1", core_trans_ready_o); end
        tests++; if (bus_trans_addr_o !== 32'h0000_0100) begin fails++; $display("FAIL pt_addr got %h want 00000100", bus_trans_addr_o); end
        tests++; if ({bus_trans_we_o, bus_trans_bufferable_o, bus_trans_cacheable_o} !== 3'b010) begin fails++; $display("FAIL pt_attr got %b want 010", {bus_trans_we_o, bus_trans_bufferable_o, bus_trans_cacheable_o}); end
        bus_trans_ready_i = 1'b0;
        #1;
        tests++; if (core_trans_ready_o !== 1'b0) begin fails++; $display("FAIL pt_ready_follow got %b want 0", core_trans_ready_o); end
        bus_trans_ready_i = 1'b1;
        cyc();
        idle_inputs();
        #1;
        tests++; if (dut.cnt !== 3'd1) begin fails++; $display("FAIL pt_cnt_inc got %0d want 1", dut.cnt); end
        bus_resp_valid_i = 1'b1;
        bus_resp_rdata_i = 32'hDEAD_BEEF;
        #1;
        tests++; if (core_resp_valid_o !== 1'b1) begin fails++; $display("FAIL pt_resp_valid got %b want 1", core_resp_valid_o); end
        tests++; if (core_resp_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL pt_rdata got %h want deadbeef", core_resp_rdata_o); end
        tests++; if ({core_resp_err_o, core_resp_pma_err_o} !== 2'b00) begin fails++; $display("FAIL pt_resp_err got %b want 00", {core_resp_err_o, core_resp_pma_err_o}); end
        bus_resp_err_i = 1'b1;
        #1;
        tests++; if (core_resp_err_o !== 1'b1) begin fails++; $display("FAIL pt_bus_err got %b want 1", core_resp_err_o); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (dut.cnt !== 3'd0) begin fails++; $display("FAIL pt_cnt_dec got %0d want 0", dut.cnt); end
    endtask

    task automatic test_pma_err();
        core_trans_valid_i = 1'b1;
        core_trans_addr_i  = 32'h0000_0200;
        pma_err_i          = 1'b1;
        #1;
        tests++; if (core_trans_ready_o !== 1'b1) begin fails++; $display("FAIL pma_ready got %b want 1", core_trans_ready_o); end
        tests++; if (bus_trans_valid_o !== 1'b0) begin fails++; $display("FAIL pma_bus_valid got %b want 0", bus_trans_valid_o); end
        cyc();
        core_trans_valid_i = 1'b1;
        pma_err_i          = 1'b0;
        bus_resp_rdata_i   = 32'h1234_5678;
        #1;
        tests++; if (core_resp_valid_o !== 1'b1) begin fails++; $display("FAIL pma_resp_valid got %b want 1", core_resp_valid_o); end
        tests++; if ({core_resp_pma_err_o, core_resp_err_o} !== 2'b10) begin fails++; $display("FAIL pma_resp_flags got %b want 10", {core_resp_pma_err_o, core_resp_err_o}); end
        tests++; if (core_resp_rdata_o !== 32'h0) begin fails++; $display("FAIL pma_rdata got %h want 00000000", core_resp_rdata_o); end
        tests++; if ({core_trans_ready_o, bus_trans_valid_o} !== 2'b00) begin fails++; $display("FAIL pma_wait_block got %b want 00", {core_trans_ready_o, bus_trans_valid_o}); end
        core_trans_valid_i = 1'b0;
        cyc();
        idle_inputs();
        #1;
        tests++; if (core_resp_valid_o !== 1'b0) begin fails++; $display("FAIL pma_one_cycle got %b want 0", core_resp_valid_o); end
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL pma_back_idle got %0d want IDLE", dut.state); end
    endtask

    task automatic test_err_order();
        issue(32'h0000_0300);
        issue(32'h0000_0304);
        #1;
        tests++; if (dut.cnt !== 3'd2) begin fails++; $display("FAIL ord_cnt got %0d want 2", dut.cnt); end
        bus_resp_valid_i = 1'b1;
        bus_resp_rdata_i = 32'h0000_00A1;
        cyc();
        bus_resp_valid_i   = 1'b0;
        core_trans_valid_i = 1'b1;
        pma_err_i          = 1'b1;
        #1;
        tests++; if (core_trans_ready_o !== 1'b1) begin fails++; $display("FAIL ord_pma_accept got %b want 1", core_trans_ready_o); end
        cyc();
        pma_err_i = 1'b0;
        #1;
        tests++; if (core_resp_valid_o !== 1'b0) begin fails++; $display("FAIL ord_early_resp got %b want 0", core_resp_valid_o); end
        tests++; if ({core_trans_ready_o, bus_trans_valid_o} !== 2'b00) begin fails++; $display("FAIL ord_wait_block got %b want 00", {core_trans_ready_o, bus_trans_valid_o}); end
        core_trans_valid_i = 1'b0;
        cyc();
        bus_resp_valid_i = 1'b1;
        bus_resp_rdata_i = 32'h0000_00A2;
        #1;
        tests++; if ({core_resp_valid_o, core_resp_pma_err_o} !== 2'b10) begin fails++; $display("FAIL ord_bus_resp got %b want 10", {core_resp_valid_o, core_resp_pma_err_o}); end
        tests++; if (core_resp_rdata_o !== 32'h0000_00A2) begin fails++; $display("FAIL ord_bus_rdata got %h want 000000a2", core_resp_rdata_o); end
        cyc();
        idle_inputs();
        #1;
        tests++; if ({core_resp_valid_o, core_resp_pma_err_o} !== 2'b11) begin fails++; $display("FAIL ord_err_resp got %b want 11", {core_resp_valid_o, core_resp_pma_err_o}); end
        cyc();
        #1;
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL ord_idle got %0d want IDLE", dut.state); end
    endtask

    task automatic test_full();
        issue(32'h0000_0400);
        issue(32'h0000_0404);
        core_trans_valid_i = 1'b1;
        pma_err_i          = 1'b1;
        #1;
        tests++; if ({core_trans_ready_o, bus_trans_valid_o} !== 2'b00) begin fails++; $display("FAIL full_pma_block got %b want 00", {core_trans_ready_o, bus_trans_valid_o}); end
        pma_err_i = 1'b0;
        #1;
        tests++; if ({core_trans_ready_o, bus_trans_valid_o} !== 2'b00) begin fails++; $display("FAIL full_block got %b want 00", {core_trans_ready_o, bus_trans_valid_o}); end
        bus_resp_valid_i = 1'b1;
        #1;
        tests++; if (bus_trans_valid_o !== 1'b0) begin fails++; $display("FAIL full_no_comb got %b want 0", bus_trans_valid_o); end
        cyc();
        #1;
        tests++; if (dut.cnt !== 3'd1) begin fails++; $display("FAIL full_drop got %0d want 1", dut.cnt); end
        tests++; if (bus_trans_valid_o !== 1'b1) begin fails++; $display("FAIL full_sim_hs got %b want 1", bus_trans_valid_o); end
        cyc();
        bus_resp_valid_i = 1'b0;
        #1;
        tests++; if (dut.cnt !== 3'd1) begin fails++; $display("FAIL full_hold got %0d want 1", dut.cnt); end
        cyc();
        core_trans_valid_i = 1'b0;
        #1;
        tests++; if (dut.cnt !== 3'd2) begin fails++; $display("FAIL full_refill got %0d want 2", dut.cnt); end
        bus_resp_valid_i = 1'b1;
        cyc();
        cyc();
        idle_inputs();
        #1;
        tests++; if (dut.cnt !== 3'd0) begin fails++; $display("FAIL full_drain got %0d want 0", dut.cnt); end
    endtask

    task automatic test_spurious();
        bus_resp_valid_i = 1'b1;
        bus_resp_rdata_i = 32'hBAD0_0BAD;
        #1;
        tests++; if (core_resp_valid_o !== 1'b0) begin fails++; $display("FAIL spur_resp got %b want 0", core_resp_valid_o); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (dut.cnt !== 3'd0) begin fails++; $display("FAIL spur_cnt got %0d want 0", dut.cnt); end
        tests++; if (resp_protocol_err_o !== proto_exp) begin fails++; $display("FAIL spur_proto got %b want %b", resp_protocol_err_o, proto_exp); end
        cyc();
        cyc();
        #1;
        tests++; if (resp_protocol_err_o !== proto_exp) begin fails++; $display("FAIL spur_sticky got %b want %b", resp_protocol_err_o, proto_exp); end
    endtask

    task automatic test_reset_err_wait();
        core_trans_valid_i = 1'b1;
        pma_err_i          = 1'b1;
        cyc();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        tests++; if (core_resp_valid_o !== 1'b0) begin fails++; $display("FAIL rew_resp_in_rst got %b want 0", core_resp_valid_o); end
        cyc();
        rst_n = 1'b1;
        #1;
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL rew_state got %0d want IDLE", dut.state); end
        tests++; if (dut.cnt !== 3'd0) begin fails++; $display("FAIL rew_cnt got %0d want 0", dut.cnt); end
        tests++; if (resp_protocol_err_o !== 1'b0) begin fails++; $display("FAIL rew_proto got %b want 0", resp_protocol_err_o); end
        cyc();
        #1;
        tests++; if (core_resp_valid_o !== 1'b0) begin fails++; $display("FAIL rew_no_resp got %b want 0", core_resp_valid_o); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
`ifdef CV32E40X_MPU_RESP_PROTOCOL_CHECK_EN
        proto_exp = 1'b1;
`else
        proto_exp = 1'b0;
`endif
        test_reset();
        test_pass_through();
        test_pma_err();
        test_err_order();
        test_full();
        test_spurious();
        test_reset_err_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_cv32e40x_mpu_resp
